sim_uart_status_monitor: RTL

// - Sim-only UART sink on the chip-level UART TX pad (cio_uart_tx_d2p) in the Verilator/DV chip top.
// - Deserialises 8N1 bytes and publishes each byte.
// - Scans the byte stream for the line-start verdict strings "PASS!" / "FAIL!".
// - Raises sticky done/passed flags so the TB can end the sim; independent of the sim_sram path.

---
 rtl/sim_uart_mon_pkg.sv | 29 ++
 rtl/sim_uart_mon_if.sv | 41 ++++
 rtl/sim_uart_mon_rx.sv | 124 ++++++++++++
 rtl/sim_uart_status_monitor.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sim_uart_mon_pkg.sv
`default_nettype none
// =============================================================================
// Module      : sim_uart_mon_pkg
// Description : Shared types and constants for the sim-only UART status monitor.
// Revision    : 1.0 - initial release
// =============================================================================
package sim_uart_mon_pkg;

    typedef enum logic [2:0] {
        RxIdle     = 3'd0,
        RxStart    = 3'd1,
        RxData     = 3'd2,
        RxStop     = 3'd3,
        RxWaitIdle = 3'd4
    } rx_state_e;

    localparam int unsigned StrLen = 5;

    localparam logic [7:0] PassStr [StrLen] = '{8'h50, 8'h41, 8'h53, 8'h53, 8'h21};
    localparam logic [7:0] FailStr [StrLen] = '{8'h46, 8'h41, 8'h49, 8'h4C, 8'h21};
    localparam logic [7:0] LineFeed         = 8'h0A;

    // Clocks per UART bit; truncating division matches the sender's own rounding.
    function automatic int unsigned div_calc(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sim_uart_mon_if.sv
`default_nettype none
// =============================================================================
// Module      : sim_uart_mon_if
// Description : Serial input and status outputs of the UART status monitor.
// Revision    : 1.0 - initial release
// =============================================================================
interface sim_uart_mon_if;

    logic        rx_i;
    logic        rx_valid_o;
    logic [7:0]  rx_data_o;
    logic        frame_err_o;
    logic        done_o;
    logic        passed_o;
    logic        timeout_o;
    logic [31:0] char_cnt_o;

    modport master (
        input  rx_i,
        output rx_valid_o,
        output rx_data_o,
        output frame_err_o,
        output done_o,
        output passed_o,
        output timeout_o,
        output char_cnt_o
    );

    modport slave (
        output rx_i,
        input  rx_valid_o,
        input  rx_data_o,
        input  frame_err_o,
        input  done_o,
        input  passed_o,
        input  timeout_o,
        input  char_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/sim_uart_mon_rx.sv
`default_nettype none
// =============================================================================
// Module      : sim_uart_mon_rx
// Description : 8N1 deserialiser: 2-flop synchroniser, bit timer and receive FSM.
// Revision    : 1.0 - initial release
// =============================================================================
module sim_uart_mon_rx
    import sim_uart_mon_pkg::*;
#(
    parameter int unsigned Div = 69
) (
    input  wire         clk_i,
    input  wire         rst_i,
    input  wire         rx_i,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        frame_err
);

    localparam int unsigned     CntW   = $clog2(Div);
    localparam logic [CntW-1:0] c_full = CntW'(Div - 1);
    localparam logic [CntW-1:0] c_half = CntW'(Div / 2 - 1);

    logic            r_rx_meta;
    logic            r_rx_s;
    rx_state_e       r_state,  w_state_nxt;
    logic [CntW-1:0] r_cnt,    w_cnt_nxt;
    logic [2:0]      r_bit,    w_bit_nxt;
    logic [7:0]      r_shift,  w_shift_nxt;
    logic            r_valid,  w_valid_nxt;
    logic [7:0]      r_data,   w_data_nxt;
    logic            r_ferr,   w_ferr_nxt;

    // Synchroniser resets to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= RxIdle;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_valid   <= w_valid_nxt;
            r_data    <= w_data_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CntW'(1) : r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_valid_nxt = 1'b0;
        w_data_nxt  = r_data;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            RxIdle: begin
                if (!r_rx_s) begin
                    w_state_nxt = RxStart;
                    w_cnt_nxt   = c_half;
                end
            end
            RxStart: begin
                if (r_cnt == '0) begin
                    if (r_rx_s) begin
                        w_state_nxt = RxIdle;
                    end else begin
                        w_state_nxt = RxData;
                        w_cnt_nxt   = c_full;
                        w_bit_nxt   = 3'd0;
                    end
                end
            end
            RxData: begin
                if (r_cnt == '0) begin
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_cnt_nxt   = c_full;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = RxStop;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            RxStop: begin
                if (r_cnt == '0) begin
                    if (r_rx_s) begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = r_shift;
                        w_state_nxt = RxIdle;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = RxWaitIdle;
                    end
                end
            end
            RxWaitIdle: begin
                if (r_rx_s) begin
                    w_state_nxt = RxIdle;
                end
            end
            default: begin
                w_state_nxt = RxIdle;
            end
        endcase
    end

    assign rx_valid  = r_valid;
    assign rx_data   = r_data;
    assign frame_err = r_ferr;

endmodule
`default_nettype wire

// File: rtl/sim_uart_status_monitor.sv
`default_nettype none
// =============================================================================
// Module      : sim_uart_status_monitor
// Description : Sim-only UART sink that flags line-start "PASS!"/"FAIL!" verdicts.
//               Optional idle watchdog enabled by SIM_UART_MON_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module sim_uart_status_monitor
    import sim_uart_mon_pkg::*;
#(
    parameter int unsigned ClkFreq    = 500_000,
    parameter int unsigned Baud       = 7_200,
    parameter int unsigned TimeoutCyc = 2**20
) (
    input  wire            clk_i,
    input  wire            rst_i,
    sim_uart_mon_if.master bus
);

    localparam int unsigned c_div      = div_calc(ClkFreq, Baud);
    localparam logic [2:0]  c_last_idx = 3'(StrLen - 1);

    logic        w_rx_valid;
    logic [7:0]  w_rx_data;
    logic        w_frame_err;

    logic        r_line_start, w_line_start_nxt;
    logic [2:0]  r_idx_p,      w_idx_p_nxt;
    logic [2:0]  r_idx_f,      w_idx_f_nxt;
    logic        w_hit_pass;
    logic        w_hit_fail;
    logic        r_done;
    logic        r_passed;
    logic [31:0] r_char_cnt;
    logic        w_wdog_fire;

    sim_uart_mon_rx #(
        .Div (c_div)
    ) u_rx (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rx_i      (bus.rx_i),
        .rx_valid  (w_rx_valid),
        .rx_data   (w_rx_data),
        .frame_err (w_frame_err)
    );

    // Index 0 may only advance at the start of a line; a completed string rewinds.
    always_comb begin
        w_line_start_nxt = r_line_start;
        w_idx_p_nxt      = r_idx_p;
        w_idx_f_nxt      = r_idx_f;
        w_hit_pass       = 1'b0;
        w_hit_fail       = 1'b0;
        if (w_frame_err) begin
            w_idx_p_nxt = 3'd0;
            w_idx_f_nxt = 3'd0;
        end else if (w_rx_valid) begin
            w_line_start_nxt = (w_rx_data == LineFeed);
            w_idx_p_nxt      = 3'd0;
            w_idx_f_nxt      = 3'd0;
            if ((w_rx_data == PassStr[r_idx_p]) && ((r_idx_p != 3'd0) || r_line_start)) begin
                if (r_idx_p == c_last_idx) begin
                    w_hit_pass = 1'b1;
                end else begin
                    w_idx_p_nxt = r_idx_p + 3'd1;
                end
            end
            if ((w_rx_data == FailStr[r_idx_f]) && ((r_idx_f != 3'd0) || r_line_start)) begin
                if (r_idx_f == c_last_idx) begin
                    w_hit_fail = 1'b1;
                end else begin
                    w_idx_f_nxt = r_idx_f + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_line_start <= 1'b1;
            r_idx_p      <= 3'd0;
            r_idx_f      <= 3'd0;
            r_done       <= 1'b0;
            r_passed     <= 1'b0;
            r_char_cnt   <= '0;
        end else begin
            r_line_start <= w_line_start_nxt;
            r_idx_p      <= w_idx_p_nxt;
            r_idx_f      <= w_idx_f_nxt;
            if (w_rx_valid && (r_char_cnt != 32'hFFFF_FFFF)) begin
                r_char_cnt <= r_char_cnt + 32'd1;
            end
            // First verdict wins; later matches leave the flags untouched.
            if (!r_done) begin
                if (w_hit_pass || w_hit_fail) begin
                    r_done   <= 1'b1;
                    r_passed <= w_hit_pass;
                end else if (w_wdog_fire) begin
                    r_done   <= 1'b1;
                    r_passed <= 1'b0;
                end
            end
        end
    end

`ifdef SIM_UART_MON_TIMEOUT_EN
    logic [31:0] r_wdog;
    logic        r_timeout;

    assign w_wdog_fire = !r_done && !w_rx_valid && ((r_wdog + 32'd1) == 32'(TimeoutCyc));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_rx_valid) begin
                r_wdog <= '0;
            end else if (!r_done) begin
                r_wdog <= r_wdog + 32'd1;
            end
            if (w_wdog_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.timeout_o = r_timeout;
`else
    wire w_unused_timeout_cfg = (TimeoutCyc == 0);

    assign w_wdog_fire   = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    assign bus.rx_valid_o  = w_rx_valid;
    assign bus.rx_data_o   = w_rx_data;
    assign bus.frame_err_o = w_frame_err;
    assign bus.done_o      = r_done;
    assign bus.passed_o    = r_passed;
    assign bus.char_cnt_o  = r_char_cnt;

endmodule
`default_nettype wire
